// File: rtl/reg_desloc_param_if.sv
// reg_desloc_param bus: control, data and status of the shift unit.
// The master drives operations, the slave (shifter) returns state.
interface reg_desloc_param_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic               enable;
  logic [2:0]         select;
  logic [WIDTH-1:0]   data;
  logic               ser_in;
  logic               start;
  logic [SHAMT_W-1:0] amount;
  logic [WIDTH-1:0]   out;
  logic               ser_out;
  logic               busy;
  logic               done;

  modport master (
    output enable, select, data,
    output ser_in, start, amount,
    input  out, ser_out, busy, done
  );

  modport slave (
    input  enable, select, data,
    input  ser_in, start, amount,
    output out, ser_out, busy, done
  );
endinterface

// File: rtl/reg_desloc_param.sv
// Parametrised universal shift register with serial in/out,
// rotate/arith modes and a multi-cycle shift-by-N sequencer.
module reg_desloc_param #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input logic               clk,
  input logic               rst,
  reg_desloc_param_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state, state_n;
  logic [2:0]         op_q, op_n, op;
  logic [SHAMT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0]   q, q_n;
  logic               so, so_n;
  logic               run, seq;
  logic               busy_q, done_q;

  always_comb begin
    state_n = state;
    op_n    = op_q;
    cnt_n   = cnt;
    op      = bus.select;
    run     = 1'b0;
    seq     = 1'b0;
    unique case (state)
      SHIFT: begin
        op    = op_q;
        run   = 1'b1;
        seq   = 1'b1;
        cnt_n = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1))
          state_n = DONE;
      end
      default: begin
        if (bus.start) begin
          op_n    = bus.select;
          cnt_n   = bus.amount;
          state_n = (bus.amount != '0) ? SHIFT : DONE;
        end else begin
          state_n = IDLE;
          run     = bus.enable;
        end
      end
    endcase
  end

  // load/clear are delay-only when replayed by the sequencer
  always_comb begin
    q_n  = q;
    so_n = so;
    if (run) begin
      case (op)
        3'b001: if (!seq) q_n = bus.data;
        3'b010: begin
          q_n  = {q[WIDTH-2:0], bus.ser_in};
          so_n = q[WIDTH-1];
        end
        3'b011: begin
          q_n  = {bus.ser_in, q[WIDTH-1:1]};
          so_n = q[0];
        end
        3'b100: begin
          q_n  = {q[WIDTH-2:0], q[WIDTH-1]};
          so_n = q[WIDTH-1];
        end
        3'b101: begin
          q_n  = {q[0], q[WIDTH-1:1]};
          so_n = q[0];
        end
        3'b110: begin
          q_n  = {q[WIDTH-1], q[WIDTH-1:1]};
          so_n = q[0];
        end
        3'b111: begin
          if (!seq) begin
            q_n  = '0;
            so_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      cnt    <= '0;
      q      <= '0;
      so     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      op_q   <= op_n;
      cnt    <= cnt_n;
      q      <= q_n;
      so     <= so_n;
      busy_q <= (state_n == SHIFT);
      done_q <= (state_n == DONE);
    end
  end

  assign bus.out     = q;
  assign bus.ser_out = so;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: doc/reg_desloc_param.md
# reg_desloc_param

Parametrised universal shift register, successor to the fixed 4-bit `reg_desloc`. It adds configurable width, serial in/out, rotate and arithmetic-shift modes, and a multi-cycle "shift by N" sequencer with a start/busy/done handshake. It sits in the datapath as the shift/rotate unit between the register file and the ALU result bus.

## Interface
- `WIDTH`, default 8: data width in bits; must be ≥ 2.
- `SHAMT_W`, default 3: width of `amount`; must satisfy 2^SHAMT_W ≥ WIDTH.

- `clk` in, 1: clock; all state changes on the rising edge.
- `rst` in, 1: reset, asynchronous, active-high.
- `enable` in, 1: qualifies single-cycle operations.
- `select` in, 3: operation code.
- `data` in, WIDTH: parallel load value.
- `ser_in` in, 1: serial input bit for logical shifts.
- `start` in, 1: request a multi-cycle shift of `amount` steps.
- `amount` in, SHAMT_W: step count, sampled when `start` is accepted.
- `out` out, WIDTH: register contents.
- `ser_out` out, 1: last bit shifted or rotated out.
- `busy` out, 1: multi-cycle shift in progress.
- `done` out, 1: one-cycle pulse when a multi-cycle shift ends.

## Operation
- `select` codes:
  - 000: hold.
  - 001: load `data`.
  - 010: SHL; `ser_in` enters the LSB, the MSB exits.
  - 011: SHR; `ser_in` enters the MSB, the LSB exits.
  - 100: ROL.
  - 101: ROR.
  - 110: ASR; the MSB is replicated, the LSB exits.
  - 111: clear.
- `ser_out` takes the exiting bit on 010–110.
  - Holds its value on 000/001.
  - Goes to 0 on 111.
  - For ROL it is the old MSB; for ROR it is the old LSB.
- FSM states: IDLE, SHIFT, DONE. DONE behaves as IDLE for accepting new work.
- In IDLE or DONE:
  - `start`=1 is accepted. The FSM latches `select` into `op_q` and `amount` into `cnt`, and does not modify `out` that edge.
  - `start` has priority over `enable`.
  - Next state is SHIFT if `amount` ≠ 0, else DONE.
- In IDLE or DONE with `start`=0 and `enable`=1: the `select` op executes once, and the next state is IDLE.
- In SHIFT, each edge:
  - Applies `op_q` once, sampling `ser_in` live; `cnt` decrements.
  - When `cnt` reaches 0, next state is DONE.
  - `enable`, `select`, `start` and `amount` are ignored.
- If `op_q` is 000, 001 or 111, the SHIFT cycles leave `out` and `ser_out` unchanged; they are pure delay. Load/clear are never applied from the sequencer.
- The counter is SHAMT_W bits. Amounts ≥ WIDTH are legal. A rotate by WIDTH returns the original value; a SHL/SHR/ASR by WIDTH or more saturates (all `ser_in` bits, or all sign bits).
- `rst` asserted at any time, including mid-SHIFT, sets:
  - `out`=0, `ser_out`=0, `busy`=0, `done`=0, `cnt`=0, state IDLE.
  - The operation is abandoned and no `done` pulse is produced.

## Timing
- Reset values: `out`=0, `ser_out`=0, `busy`=0, `done`=0.
- All outputs are registered.
- Single-cycle op: `out` and `ser_out` are valid one edge after the enabling edge.
- Start accepted at edge E0 with amount N ≥ 1:
  - Shifts occur at edges E1..EN.
  - `busy`=1 from after E0 until after EN.
  - `done`=1 for exactly the cycle after EN, with `busy`=0 in that cycle.
- N=0: `done`=1 for the cycle after E0; `busy` never rises.
- Back-to-back: `start` asserted during the `done` cycle is accepted at that edge, so `done` drops while `busy` rises.
- Throughput: one multi-cycle operation per N+1 cycles.

## Test plan
- Reset and load (`WIDTH`=4):
  - `rst`=1 → `out`=0000, `ser_out`=0, `busy`=0, `done`=0.
  - Release, then `enable`=1, `select`=001, `data`=1010 → `out`=1010 next edge.
  - `select`=000 → holds 1010.
- Single-cycle modes, each starting from 1010 with `ser_in`=1:
  - SHL → 0101, `ser_out`=1.
  - SHR → 1101, `ser_out`=0.
  - ROL → 0101, `ser_out`=1.
  - ROR → 0101, `ser_out`=0.
  - ASR → 1101, `ser_out`=0.
  - Clear → 0000, `ser_out`=0.
- Multi-cycle ROL by 3 from 1010:
  - `busy` is high for exactly 3 cycles, `out` goes 0101, 1010, 0101.
  - `done` pulses once, one cycle after the last shift.
  - Toggling `enable`/`select` while busy has no effect.
- Edge amounts:
  - `amount`=0 → `done` the next cycle, `busy` never high, `out` unchanged.
  - SHR by 7 with `ser_in`=0 from 1010 → 0000.
  - ROR by 4 from 1011 → 1011.
- Reset mid-operation: start SHL by 5, assert `rst` asynchronously (between edges) after 2 shifts → outputs drop to 0 immediately, no `done` pulse, and the next `start` behaves normally.
- Back-to-back: assert `start` (ROR, `amount`=1) during a `done` cycle → accepted, and `busy` rises the next cycle.
